// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: digit-write handshake into the scan controller's digit registers.
interface seg7_scan_ctrl_if #(parameter int NUM_DIGITS = 4);
  logic                          wr_valid;
  logic                          wr_ready;
  logic [$clog2(NUM_DIGITS)-1:0] wr_digit;
  logic [3:0]                    wr_value;
  modport master (output wr_valid, wr_digit, wr_value, input wr_ready);
  modport slave  (input wr_valid, wr_digit, wr_value, output wr_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with per-slot duty dimming and leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_scan_ctrl_if.slave       wr,
  input  logic                  enable,
  input  logic                  blank_lz,
  input  logic [2:0]            duty,
  output logic [3:0]            seg_code,
  output logic                  seg_blank,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_done
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {SHOW, GAP, ADV} state_t;
  state_t                       state_q, state_d;
  logic [PW-1:0]                psc_q, psc_d;
  logic [2:0]                   phase_q, phase_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic                         en_q;
  logic [NUM_DIGITS-1:0][3:0]   dig_q, dig_d;
  logic [NUM_DIGITS-1:0]        blank_v;
  logic                         all_zero;
  logic                         tick;
  logic [NUM_DIGITS-1:0]        digit_en_d;
  logic [3:0]                   seg_code_d;
  logic                         seg_blank_d, frame_done_d;
  assign wr.wr_ready = state_q != ADV;
  assign tick = psc_q == PW'(TICK_DIV - 1);
  always_comb begin
    dig_d = dig_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (wr.wr_valid && state_q != ADV && wr.wr_digit == IW'(i)) dig_d[i] = wr.wr_value;
    all_zero = 1'b1;
    blank_v  = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero   = all_zero && dig_q[i] == 4'd0;
      blank_v[i] = all_zero;
    end
    state_d = state_q;
    psc_d   = psc_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    if (!enable) begin
      state_d = SHOW;
      psc_d   = '0;
      phase_d = '0;
      idx_d   = '0;
    end else if (en_q) begin
      // the first enabled cycle holds counters at zero so every slot runs its full length
      psc_d   = tick ? '0 : psc_q + PW'(1);
      phase_d = phase_q + {2'b0, tick};
      if (state_q == ADV) begin
        state_d = SHOW;
        psc_d   = '0;
        phase_d = '0;
        idx_d   = idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1);
      end else if (tick && phase_q == 3'd7) state_d = ADV;
      else if (tick && state_q == SHOW && phase_q == duty) state_d = GAP;
    end
    digit_en_d   = (enable && state_d == SHOW) ? NUM_DIGITS'(1) << idx_d : '0;
    seg_code_d   = dig_q[idx_d];
    seg_blank_d  = blank_lz && blank_v[idx_d];
    frame_done_d = state_d == ADV && idx_q == IW'(NUM_DIGITS - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SHOW;
      psc_q        <= '0;
      phase_q      <= '0;
      idx_q        <= '0;
      en_q         <= 1'b0;
      dig_q        <= '0;
      digit_en     <= '0;
      seg_code     <= '0;
      seg_blank    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_q      <= state_d;
      psc_q        <= psc_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      en_q         <= enable;
      dig_q        <= dig_d;
      digit_en     <= digit_en_d;
      seg_code     <= seg_code_d;
      seg_blank    <= seg_blank_d;
      frame_done   <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed vector table plus hand-written timing, handshake, enable and reset sequences.
module tb_seg7_scan_ctrl;
  logic       clk = 1'b0, rst_n = 1'b1, enable = 1'b1, blank_lz = 1'b0;
  logic [2:0] duty = 3'd1;
  logic [3:0] seg_code, digit_en;
  logic       seg_blank, frame_done;
  int         tests = 0, fails = 0;
  seg7_scan_ctrl_if #(.NUM_DIGITS(4)) wif();
  seg7_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wif), .enable(enable), .blank_lz(blank_lz), .duty(duty),
    .seg_code(seg_code), .seg_blank(seg_blank), .digit_en(digit_en), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] vals;
    logic        blz;
    logic [3:0]  exp_blank;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_en(input logic [3:0] v);
    for (int i = 0; i < 200 && digit_en !== v; i++) step();
    if (digit_en !== v) chk("wait_en_timeout", int'(digit_en), int'(v));
  endtask
  task automatic wait_fd();
    for (int i = 0; i < 300 && frame_done !== 1'b1; i++) step();
    if (frame_done !== 1'b1) chk("wait_fd_timeout", 0, 1);
  endtask
  task automatic count_run(input logic [3:0] v, output int n);
    n = 0;
    while (digit_en === v && n < 100) begin
      n++;
      step();
    end
  endtask
  task automatic wr(input int d, input int v);
    wif.wr_digit = 2'(d);
    wif.wr_value = 4'(v);
    wif.wr_valid = 1'b1;
    for (int i = 0; i < 10 && wif.wr_ready !== 1'b1; i++) step();
    step();
    wif.wr_valid = 1'b0;
  endtask
  initial begin
    int n, m;
    vecs[0] = '{16'h0042, 1'b1, 4'b1100};
    vecs[1] = '{16'h0042, 1'b0, 4'b0000};
    vecs[2] = '{16'h0000, 1'b1, 4'b1110};
    vecs[3] = '{16'h1000, 1'b1, 4'b0000};
    vecs[4] = '{16'h0A00, 1'b1, 4'b1000};
    vecs[5] = '{16'h00F0, 1'b1, 4'b1100};
    vecs[6] = '{16'h0305, 1'b1, 4'b1000};
    wif.wr_valid = 1'b0;
    wif.wr_digit = '0;
    wif.wr_value = '0;
    #1 rst_n = 1'b0;
    #10;
    chk("rst_digit_en", int'(digit_en), 0);
    chk("rst_seg_code", int'(seg_code), 0);
    chk("rst_seg_blank", int'(seg_blank), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_wr_ready", int'(wif.wr_ready), 1);
    step();
    rst_n = 1'b1;
    step();
    chk("first_edge_en", int'(digit_en), 1);
    count_run(4'b0001, n);
    chk("duty1_lit", n, 4);
    count_run(4'b0000, m);
    chk("duty1_dark", m, 13);
    chk("duty1_next", int'(digit_en), 2);
    wait_fd();
    chk("fd_dark", int'(digit_en), 0);
    chk("fd_ready_low", int'(wif.wr_ready), 0);
    step();
    chk("fd_one_cycle", int'(frame_done), 0);
    n = 1;
    while (frame_done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("frame_period", n, 68);
    duty = 3'd7;
    step();
    wait_fd();
    step();
    count_run(4'b0001, n);
    chk("duty7_lit", n, 16);
    count_run(4'b0000, m);
    chk("duty7_dark", m, 1);
    chk("duty7_next", int'(digit_en), 2);
    duty = 3'd1;
    foreach (vecs[k]) begin
      blank_lz = vecs[k].blz;
      for (int d = 0; d < 4; d++) wr(d, int'((vecs[k].vals >> (4 * d)) & 16'hF));
      wait_fd();
      step();
      for (int s = 0; s < 4; s++) begin
        wait_en(4'(1 << s));
        chk($sformatf("v%0d_code%0d", k, s), int'(seg_code), int'((vecs[k].vals >> (4 * s)) & 16'hF));
        chk($sformatf("v%0d_blank%0d", k, s), int'(seg_blank), int'(vecs[k].exp_blank[s]));
      end
    end
    blank_lz = 1'b0;
    step();
    wait_fd();
    for (int i = 0; i < 16; i++) step();
    chk("pre_adv_ready", int'(wif.wr_ready), 1);
    step();
    chk("adv_ready_low", int'(wif.wr_ready), 0);
    chk("adv_dark", int'(digit_en), 0);
    wif.wr_digit = 2'd1;
    wif.wr_value = 4'd9;
    wif.wr_valid = 1'b1;
    step();
    chk("post_adv_ready", int'(wif.wr_ready), 1);
    chk("post_adv_en", int'(digit_en), 2);
    chk("held_code_old", int'(seg_code), 0);
    step();
    wif.wr_valid = 1'b0;
    chk("accept_edge_code", int'(seg_code), 0);
    step();
    chk("write_lands", int'(seg_code), 9);
    wait_en(4'b0100);
    step();
    step();
    enable = 1'b0;
    step();
    chk("dis_dark", int'(digit_en), 0);
    chk("dis_fd", int'(frame_done), 0);
    chk("dis_ready", int'(wif.wr_ready), 1);
    wr(0, 5);
    step();
    chk("dis_still_dark", int'(digit_en), 0);
    enable = 1'b1;
    step();
    chk("reen_en", int'(digit_en), 1);
    chk("reen_code", int'(seg_code), 5);
    count_run(4'b0001, n);
    chk("reen_lit", n, 4);
    count_run(4'b0000, m);
    chk("reen_dark", m, 13);
    chk("reen_next", int'(digit_en), 2);
    wait_en(4'b0001);
    step();
    chk("pre_rst_code", int'(seg_code), 5);
    #2;
    rst_n = 1'b0;
    wif.wr_digit = 2'd2;
    wif.wr_value = 4'd7;
    wif.wr_valid = 1'b1;
    #1;
    chk("async_rst_en", int'(digit_en), 0);
    chk("async_rst_code", int'(seg_code), 0);
    chk("async_rst_blank", int'(seg_blank), 0);
    chk("async_rst_fd", int'(frame_done), 0);
    step();
    wif.wr_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_en", int'(digit_en), 1);
    chk("post_rst_dig0", int'(seg_code), 0);
    wait_en(4'b0010);
    chk("post_rst_dig1", int'(seg_code), 0);
    wait_en(4'b0100);
    chk("rst_write_discard", int'(seg_code), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, 2..8.
REQ-002 Parameter TICK_DIV, default 1000: clocks per brightness phase, >=1.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  scan enable; 0 = display dark.
REQ-006 wr_valid  input  1  digit-write request.
REQ-007 wr_ready  output  1  digit-write acceptance.
REQ-008 wr_digit  input  clog2(NUM_DIGITS)  target digit index; index 0 is least significant.
REQ-009 wr_value  input  4  BCD value for target digit.
REQ-010 blank_lz  input  1  leading-zero blanking enable.
REQ-011 duty  input  3  on-time per slot in eighths, minus one (0 = 1/8, 7 = 8/8).
REQ-012 seg_code  output  4  value driven into the shared seg7 decoder counter input.
REQ-013 seg_blank  output  1  1 = force segments off for the current slot.
REQ-014 digit_en  output  NUM_DIGITS  one-hot, active-high digit common enable.
REQ-015 frame_done  output  1  one-cycle pulse at end of each full scan frame.

Function
REQ-016 The block SHALL hold NUM_DIGITS 4-bit digit registers and time-share one seg7 decoder among them.
REQ-017 A write SHALL be accepted on a rising edge where wr_valid=1 and wr_ready=1; the digit register updates at that edge.
REQ-018 wr_ready SHALL be 1 in SHOW and GAP and 0 in ADV; wr_valid may stay high across ADV without loss.
REQ-019 Writes with wr_digit >= NUM_DIGITS SHALL be accepted and discarded.
REQ-020 FSM states: SHOW (active digit lit), GAP (all digits off, remainder of slot), ADV (one cycle, all off, anti-ghosting).
REQ-021 Each slot SHALL consist of 8 phases of TICK_DIV clocks, counted by a prescaler (0..TICK_DIV-1) and phase counter (0..7).
REQ-022 SHOW -> GAP when the prescaler is terminal and phase == duty, duty < 7; SHOW -> ADV when the prescaler is terminal, phase == 7 and duty == 7.
REQ-023 GAP -> ADV when the prescaler is terminal and phase == 7.
REQ-024 ADV -> SHOW unconditionally; counters clear; scan index increments modulo NUM_DIGITS.
REQ-025 Slot length SHALL be 8*TICK_DIV+1 cycles independent of duty; frame length NUM_DIGITS*(8*TICK_DIV+1).
REQ-026 duty SHALL be sampled at each clock; a change mid-slot takes effect at the next comparison.
REQ-027 frame_done SHALL pulse for the ADV cycle in which the scan index wraps NUM_DIGITS-1 -> 0.
REQ-028 digit_en, seg_code, seg_blank SHALL be registered, computed from next-state, so they change one cycle after the state decision and never glitch.
REQ-029 In SHOW, digit_en SHALL be one-hot at the scan index; in GAP and ADV, digit_en SHALL be all zero.
REQ-030 seg_code SHALL equal the digit register at the scan index; a write to the active digit appears on seg_code at the second rising edge after acceptance.
REQ-031 With blank_lz=1, seg_blank SHALL be 1 for digit i>0 when digits NUM_DIGITS-1..i are all zero; digit 0 is never blanked; with blank_lz=0, seg_blank=0.
REQ-032 Values 10..15 SHALL pass through unmodified and count as nonzero for blanking.
REQ-033 enable=0 SHALL synchronously force state SHOW, scan index 0, counters 0, digit_en=0, frame_done=0; writes remain accepted.
REQ-034 On enable 0 -> 1, digit_en SHALL become one-hot at index 0 on the next rising edge.

Reset
REQ-035 rst_n=0 SHALL asynchronously set state SHOW, scan index 0, counters 0, all digit registers 0, digit_en=0, seg_code=0, seg_blank=0, frame_done=0.
REQ-036 After rst_n deasserts with enable=1, digit_en SHALL be 0001 from the first rising edge.
REQ-037 Reset asserted mid-slot or during a write SHALL abort the slot and discard the write.

Verification
REQ-038 TICK_DIV=2, duty=1, enable=1 -> digit_en 0001 for 4 cycles, 0000 for 13 cycles, then 0010; frame_done pulses every 68 cycles.
REQ-039 duty=7 -> digit_en lit 16 cycles, 1 ADV cycle of 0000, no GAP.
REQ-040 Write digits 3..0 = 0,0,4,2 with blank_lz=1 -> seg_blank 1 on slots 3,2; 0 on slots 1,0; seg_code 2,4 on slots 0,1.
REQ-041 Hold wr_valid=1 across an ADV cycle -> wr_ready 0 for exactly that cycle; write lands on the following edge.
REQ-042 Drop enable mid-slot 2 -> digit_en 0000 next edge; re-raise -> 0001, full slot timing from zero.
REQ-043 Pulse rst_n low mid-SHOW -> outputs and digit registers zero immediately, without a clock edge.
